div_recon: RTL

Sequential multiply-accumulate unit that computes `result = quotient * divisor + remainder`, the inverse of the pipelined divider `div`. It reconstructs a dividend from a divider output triple, so it can close the loop around `div` in self-checking benches and in-system divider checks. It serves any datapath that needs an exact `a*b+c` at one bit per cycle with minimal area. A start/done handshake frames each operation, and only one operation is in flight at a time.

---
 rtl/div_recon_pkg.sv | 23 ++
 rtl/div_recon.sv | 85 ++++++++
 2 files changed

// File: rtl/div_recon_pkg.sv
// ============================================================================
// Module  : div_recon_pkg
// Brief   : Shared state encoding and sizing helper for the div_recon MAC.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package div_recon_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Wide enough to hold the iteration count DATA_W itself.
  function automatic int cnt_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/div_recon.sv
// ============================================================================
// Module  : div_recon
// Brief   : Bit-serial unsigned quotient*divisor+remainder, one bit per cycle.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module div_recon
  import div_recon_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [DATA_W-1:0]   quotient,
  input  logic [DATA_W-1:0]   divisor,
  input  logic [DATA_W-1:0]   remainder,
  output logic                busy,
  output logic                done,
  output logic [2*DATA_W-1:0] result
);

  localparam int CNT_W = cnt_width(DATA_W);

  state_t              r_state;
  state_t              w_state_next;
  logic [2*DATA_W-1:0] r_acc;
  logic [2*DATA_W-1:0] r_mcand;
  logic [2*DATA_W-1:0] w_sum;
  logic [DATA_W-1:0]   r_mplier;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_busy;
  logic                r_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_state_next = S_RUN;
      S_RUN:   if (r_cnt == CNT_W'(1)) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_sum = r_acc + r_mcand;

  // Status flags are registered from the next state so they align with r_state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_busy <= (w_state_next == S_RUN);
      r_done <= (w_state_next == S_DONE);
      if (r_state == S_IDLE && start) begin
        r_acc    <= {{DATA_W{1'b0}}, remainder};
        r_mcand  <= {{DATA_W{1'b0}}, divisor};
        r_mplier <= quotient;
        r_cnt    <= CNT_W'(DATA_W);
      end else if (r_state == S_RUN) begin
        if (r_mplier[0]) r_acc <= w_sum;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt - CNT_W'(1);
      end
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_acc;

endmodule

`default_nettype wire
